epl_column_write_seq: RTL and testbench

Two-phase column write sequencer for the EPLFFRAM02 column path. It accepts one 14-bit row word (two 7-bit codewords) from the write controller and drives the column access sub-block's one-hot `pAcy`, `pValide` and `pCodeword` inputs through an even-column phase and then an odd-column phase. Each phase gets a programmable write-pulse width and a settling gap. It sits between the array write controller and the column access sub-block, and is the only driver of that sub-block's inputs.

---
 rtl/epl_column_write_seq_if.sv | 26 ++
 rtl/epl_column_write_seq.sv | 176 +++++++++++++++++
 tb/tb_epl_column_write_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/epl_column_write_seq_if.sv
// Handshake and column-drive bundle between the write controller, the
// column write sequencer and the column access sub-block.
interface epl_column_write_seq_if #(
    parameter int TWORD_WIDTH = 7,
    parameter int ADDR_AYO    = 2
);
    logic                       pReq_i;
    logic [2*TWORD_WIDTH-1:0]   pData_i;
    logic [1:0]                 pPhaseEn_i;
    logic                       pAck_o;
    logic                       pBusy_o;
    logic                       pDone_o;
    logic [ADDR_AYO-1:0]        pAcy_o;
    logic                       pValide_o;
    logic [TWORD_WIDTH-1:0]     pCodeword_o;

    modport master (
        output pReq_i, pData_i, pPhaseEn_i,
        input  pAck_o, pBusy_o, pDone_o, pAcy_o, pValide_o, pCodeword_o
    );

    modport slave (
        input  pReq_i, pData_i, pPhaseEn_i,
        output pAck_o, pBusy_o, pDone_o, pAcy_o, pValide_o, pCodeword_o
    );
endinterface

// File: rtl/epl_column_write_seq.sv
// Two-phase (even/odd) column write sequencer with programmable pulse and gap.
// Define EPL_COLSEQ_SKIP_EN to let pPhaseEn_i select which phases run.
module epl_column_write_seq #(
    parameter int P_WE_CYCLES  = 4,
    parameter int P_GAP_CYCLES = 1,
    parameter int TWORD_WIDTH  = 7,
    parameter int ADDR_AYO     = 2
) (
    input  logic                   pClk_i,
    input  logic                   nRst_i,
    epl_column_write_seq_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_GAP, S_DONE} state_t;
    typedef enum logic {PH_EVEN, PH_ODD} phase_t;

    state_t                     state_q, state_d;
    phase_t                     ph_q, ph_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       en_odd_q, en_odd_d;
    logic                       load_data;
    logic [2*TWORD_WIDTH-1:0]   data_q;
    logic [1:0]                 en_eff;

    logic                       ack_q, ack_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [ADDR_AYO-1:0]        acy_q, acy_d;
    logic                       valide_q, valide_d;
    logic [TWORD_WIDTH-1:0]     cw_q, cw_d;

`ifdef EPL_COLSEQ_SKIP_EN
    assign en_eff = bus.pPhaseEn_i;
`else
    logic unused_phase_en;
    assign unused_phase_en = ^bus.pPhaseEn_i;
    assign en_eff = 2'b11;
`endif

    function automatic logic [ADDR_AYO-1:0] onehot(input phase_t p);
        return (p == PH_ODD) ? ADDR_AYO'(2'b10) : ADDR_AYO'(2'b01);
    endfunction

    function automatic logic [TWORD_WIDTH-1:0] pick(input logic [2*TWORD_WIDTH-1:0] d,
                                                    input phase_t p);
        return (p == PH_ODD) ? d[2*TWORD_WIDTH-1:TWORD_WIDTH] : d[TWORD_WIDTH-1:0];
    endfunction

    // Outputs are computed for the next state and registered, so every
    // output changes exactly on the edge that enters the corresponding state.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        cnt_d     = cnt_q;
        en_odd_d  = en_odd_q;
        load_data = 1'b0;
        ack_d     = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        acy_d     = acy_q;
        valide_d  = 1'b0;
        cw_d      = cw_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                acy_d  = '0;
                cw_d   = '0;
                if (bus.pReq_i) begin
                    ack_d     = 1'b1;
                    busy_d    = 1'b1;
                    load_data = 1'b1;
                    en_odd_d  = en_eff[1];
                    if (en_eff[0]) begin
                        state_d = S_SETUP;
                        ph_d    = PH_EVEN;
                        acy_d   = onehot(PH_EVEN);
                        cw_d    = pick(bus.pData_i, PH_EVEN);
                    end else if (en_eff[1]) begin
                        state_d = S_SETUP;
                        ph_d    = PH_ODD;
                        acy_d   = onehot(PH_ODD);
                        cw_d    = pick(bus.pData_i, PH_ODD);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_d  = S_PULSE;
                cnt_d    = 8'(P_WE_CYCLES);
                valide_d = 1'b1;
            end
            S_PULSE: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_GAP;
                    cnt_d   = 8'(P_GAP_CYCLES);
                end else begin
                    cnt_d    = cnt_q - 8'd1;
                    valide_d = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd1) begin
                    if (ph_q == PH_EVEN && en_odd_q) begin
                        state_d = S_SETUP;
                        ph_d    = PH_ODD;
                        acy_d   = onehot(PH_ODD);
                        cw_d    = pick(data_q, PH_ODD);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        acy_d   = '0;
                        cw_d    = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                acy_d   = '0;
                cw_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                acy_d   = '0;
                cw_d    = '0;
            end
        endcase
    end

    always_ff @(posedge pClk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            state_q  <= S_IDLE;
            ph_q     <= PH_EVEN;
            cnt_q    <= '0;
            en_odd_q <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acy_q    <= '0;
            valide_q <= 1'b0;
            cw_q     <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            en_odd_q <= en_odd_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acy_q    <= acy_d;
            valide_q <= valide_d;
            cw_q     <= cw_d;
        end
    end

    // Row word is only captured at acceptance, so later input changes are ignored.
    always_ff @(posedge pClk_i) begin
        if (load_data) begin
            data_q <= bus.pData_i;
        end
    end

    assign bus.pAck_o      = ack_q;
    assign bus.pBusy_o     = busy_q;
    assign bus.pDone_o     = done_q;
    assign bus.pAcy_o      = acy_q;
    assign bus.pValide_o   = valide_q;
    assign bus.pCodeword_o = cw_q;

endmodule

// File: tb/tb_epl_column_write_seq.sv
// Directed bench for epl_column_write_seq: default timing (W=4,G=1) on one
// instance, minimal timing (W=1,G=1) on a second, plus reset/handshake corners.
module tb_epl_column_write_seq;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    epl_column_write_seq_if ifa ();
    epl_column_write_seq_if ifb ();

    epl_column_write_seq #(.P_WE_CYCLES(4), .P_GAP_CYCLES(1)) dut_a (
        .pClk_i(clk), .nRst_i(nrst), .bus(ifa)
    );
    epl_column_write_seq #(.P_WE_CYCLES(1), .P_GAP_CYCLES(1)) dut_b (
        .pClk_i(clk), .nRst_i(nrst), .bus(ifb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Output vector: {ack, busy, done, acy[1:0], valide, codeword[6:0]}
    typedef struct {
        int          sel;
        int          lo;
        int          hi;
        logic [12:0] exp;
        logic [12:0] mask;
    } vec_t;

    localparam logic [12:0] FULL = 13'h1FFF;
    localparam logic [12:0] NOCW = 13'h1F80;

    vec_t tbl [16];

    function automatic logic [12:0] mk(logic a, logic b, logic dn, logic [1:0] ay,
                                       logic v, logic [6:0] cw);
        return {a, b, dn, ay, v, cw};
    endfunction

    function automatic logic [12:0] get_out(int sel);
        if (sel == 0)
            return {ifa.pAck_o, ifa.pBusy_o, ifa.pDone_o, ifa.pAcy_o, ifa.pValide_o, ifa.pCodeword_o};
        return {ifb.pAck_o, ifb.pBusy_o, ifb.pDone_o, ifb.pAcy_o, ifb.pValide_o, ifb.pCodeword_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic req, input logic [13:0] d, input logic [1:0] en);
        if (sel == 0) begin
            ifa.pReq_i = req; ifa.pData_i = d; ifa.pPhaseEn_i = en;
        end else begin
            ifb.pReq_i = req; ifb.pData_i = d; ifb.pPhaseEn_i = en;
        end
    endtask

    // Starts just after a rising edge; the next edge is the acceptance edge E0.
    task automatic run_table(input int sel, input logic [13:0] d, input int first, input int last);
        int cyc;
        logic [12:0] o;
        set_in(sel, 1'b1, d, 2'b11);
        @(posedge clk);
        cyc = 0;
        for (int i = first; i <= last; i++) begin
            for (int c = tbl[i].lo; c <= tbl[i].hi; c++) begin
                while (cyc < c) begin
                    @(negedge clk);
                    cyc++;
                    if (cyc == 1) set_in(sel, 1'b0, d, 2'b11);
                end
                o = get_out(sel);
                chk($sformatf("tbl%0d_cyc%0d", i, c), 32'(o & tbl[i].mask), 32'(tbl[i].exp & tbl[i].mask));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic measure(input int sel, input logic [13:0] d, input logic [1:0] en,
                           output int done_cyc, output int val_cnt, output logic [12:0] first);
        logic [12:0] o;
        set_in(sel, 1'b1, d, en);
        @(posedge clk);
        done_cyc = -1;
        val_cnt  = 0;
        first    = '0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            o = get_out(sel);
            if (c == 1) begin
                first = o;
                set_in(sel, 1'b0, d, en);
            end
            if (o[10] && done_cyc < 0) done_cyc = c;
            if (o[7]) val_cnt++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_ack, second_ack, acks, dcyc, vcnt;
        logic [12:0] o1;

        // Default two-phase sequence, data 14'h2A55: even 7'h55, odd 7'h54
        tbl[0]  = '{0,  1,  1, mk(1, 1, 0, 2'b01, 0, 7'h55), FULL};
        tbl[1]  = '{0,  2,  5, mk(0, 1, 0, 2'b01, 1, 7'h55), FULL};
        tbl[2]  = '{0,  6,  6, mk(0, 1, 0, 2'b01, 0, 7'h55), FULL};
        tbl[3]  = '{0,  7,  7, mk(0, 1, 0, 2'b10, 0, 7'h54), FULL};
        tbl[4]  = '{0,  8, 11, mk(0, 1, 0, 2'b10, 1, 7'h54), FULL};
        tbl[5]  = '{0, 12, 12, mk(0, 1, 0, 2'b10, 0, 7'h54), FULL};
        tbl[6]  = '{0, 13, 13, mk(0, 1, 1, 2'b00, 0, 7'h00), NOCW};
        tbl[7]  = '{0, 14, 14, mk(0, 0, 0, 2'b00, 0, 7'h00), NOCW};
        // W=1, G=1 sequence, data 14'h1234: even 7'h34, odd 7'h24
        tbl[8]  = '{1,  1,  1, mk(1, 1, 0, 2'b01, 0, 7'h34), FULL};
        tbl[9]  = '{1,  2,  2, mk(0, 1, 0, 2'b01, 1, 7'h34), FULL};
        tbl[10] = '{1,  3,  3, mk(0, 1, 0, 2'b01, 0, 7'h34), FULL};
        tbl[11] = '{1,  4,  4, mk(0, 1, 0, 2'b10, 0, 7'h24), FULL};
        tbl[12] = '{1,  5,  5, mk(0, 1, 0, 2'b10, 1, 7'h24), FULL};
        tbl[13] = '{1,  6,  6, mk(0, 1, 0, 2'b10, 0, 7'h24), FULL};
        tbl[14] = '{1,  7,  7, mk(0, 1, 1, 2'b00, 0, 7'h00), NOCW};
        tbl[15] = '{1,  8,  8, mk(0, 0, 0, 2'b00, 0, 7'h00), NOCW};

        set_in(0, 1'b0, 14'h0, 2'b11);
        set_in(1, 1'b0, 14'h0, 2'b11);
        #1;
        chk("reset_a", 32'(get_out(0)), 32'h0);
        chk("reset_b", 32'(get_out(1)), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk); #1;

        run_table(0, 14'h2A55, 0, 7);
        run_table(1, 14'h1234, 8, 15);

        // Asynchronous reset in the middle of the even pulse
        set_in(0, 1'b1, 14'h2A55, 2'b11);
        @(posedge clk);
        @(negedge clk) set_in(0, 1'b0, 14'h2A55, 2'b11);
        repeat (2) @(negedge clk);
        chk("rst_pre_valide", 32'(ifa.pValide_o), 32'h1);
        #2 nrst = 1'b0;
        #1 chk("rst_immediate", 32'(get_out(0)), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("rst_hold_done%0d", k), 32'(ifa.pDone_o), 32'h0);
        end
        nrst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("rst_after_done%0d", k), 32'(ifa.pDone_o), 32'h0);
        end
        @(posedge clk); #1;
        run_table(0, 14'h2A55, 0, 7);

        // Request held across two sequences; data changes after ack are ignored
        set_in(0, 1'b1, 14'h2A55, 2'b11);
        @(posedge clk);
        first_ack  = -1;
        second_ack = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ifa.pAck_o) begin
                if (first_ack < 0) first_ack = c;
                else if (second_ack < 0) second_ack = c;
            end
            if (c == 2) ifa.pData_i = 14'h0000;
            if (c == 8) chk("hold_odd_cw", 32'(ifa.pCodeword_o), 32'h54);
            if (second_ack > 0) ifa.pReq_i = 1'b0;
        end
        chk("hold_first_ack", 32'(first_ack), 32'd1);
        chk("hold_second_ack", 32'(second_ack), 32'd15);
        repeat (20) @(posedge clk); #1;

        // Request pulses while busy give no ack
        set_in(0, 1'b1, 14'h2A55, 2'b11);
        @(posedge clk);
        acks = 0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c >= 2 && ifa.pAck_o) acks++;
            if (c == 13) chk("pulse_done13", 32'(ifa.pDone_o), 32'h1);
            ifa.pReq_i = (c >= 2 && c <= 12 && (c % 2 == 0));
        end
        chk("pulse_no_ack", 32'(acks), 32'd0);
        @(posedge clk); #1;

`ifdef EPL_COLSEQ_SKIP_EN
        measure(0, 14'h2A55, 2'b10, dcyc, vcnt, o1);
        chk("odd_only_first", 32'(o1), 32'(mk(1, 1, 0, 2'b10, 0, 7'h54)));
        chk("odd_only_done", 32'(dcyc), 32'd7);
        chk("odd_only_valide", 32'(vcnt), 32'd4);
        measure(0, 14'h2A55, 2'b00, dcyc, vcnt, o1);
        chk("none_first", 32'(o1 & NOCW), 32'(mk(1, 1, 1, 2'b00, 0, 7'h00) & NOCW));
        chk("none_done", 32'(dcyc), 32'd1);
        chk("none_valide", 32'(vcnt), 32'd0);
`else
        measure(0, 14'h2A55, 2'b00, dcyc, vcnt, o1);
        chk("en_ignored_first", 32'(o1), 32'(mk(1, 1, 0, 2'b01, 0, 7'h55)));
        chk("en_ignored_done", 32'(dcyc), 32'd13);
        chk("en_ignored_valide", 32'(vcnt), 32'd8);
`endif
        measure(1, 14'h3FFF, 2'b11, dcyc, vcnt, o1);
        chk("b_done7", 32'(dcyc), 32'd7);
        chk("b_valide2", 32'(vcnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
